// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 64;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Identifies which processor port owns the memory.
    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_t;

endpackage

// File: rtl/mem_arb_req_latch.sv
// Per-port request capture: holds one outstanding request (pend flag plus
// address/data/direction) until the arbiter takes it.
module mem_arb_req_latch
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_req,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_rd,
    input  logic              owned,
    input  logic              take,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              rd
);

    // Capture a new request only when nothing is outstanding or in flight for this port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend <= 1'b0;
            addr <= '0;
            data <= '0;
            rd   <= 1'b0;
        end else if (take) begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            pend <= 1'b0;
        end else if (start_req && !pend && !owned) begin
            pend <= 1'b1;
            addr <= in_addr;
            data <= in_data;
            rd   <= in_rd;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port memory arbiter: serialises instruction and data port requests onto
// a single mem_64k startReq/reqFinish handshake.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration on simultaneous
// requests; without it the data port always wins.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              startReqI,
    input  logic [ADDR_W-1:0] inAddrI,
    output logic [DATA_W-1:0] outDataI,
    output logic              reqFinishI,
    input  logic              startReqD,
    input  logic [ADDR_W-1:0] inAddrD,
    input  logic [DATA_W-1:0] inDataD,
    input  logic              isRdD,
    output logic [DATA_W-1:0] outDataD,
    output logic              reqFinishD,
    output logic              memStartReq,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memData,
    output logic              memIsRd,
    input  logic [DATA_W-1:0] memOutData,
    input  logic              memReqFinish,
    output logic              busy
);

    arb_state_t        state;
    arb_port_t         owner;
    arb_port_t         winner;
    logic              pend_i, pend_d;
    logic              take_i, take_d;
    logic              owned_i, owned_d;
    logic              in_flight;
    logic              done;
    logic [ADDR_W-1:0] lat_addr_i, lat_addr_d;
    logic [DATA_W-1:0] lat_data_i, lat_data_d;
    logic              lat_rd_i, lat_rd_d;
`ifdef MEM_ARB_RR_EN
    arb_port_t         last_grant;
`endif

    // Choose the port that would be granted if the arbiter is idle this cycle.
    always_comb begin
        // NOTE: assign a default first so every path drives winner and no latch is inferred.
        winner = pend_d ? PORT_D : PORT_I;
`ifdef MEM_ARB_RR_EN
        if (pend_i && pend_d) begin
            winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end
`endif
    end

    assign in_flight = (state == ISSUE) || (state == WAIT);
    assign take_i    = (state == IDLE) && pend_i && (winner == PORT_I);
    assign take_d    = (state == IDLE) && pend_d && (winner == PORT_D);
    assign owned_i   = in_flight && (owner == PORT_I);
    assign owned_d   = in_flight && (owner == PORT_D);
    assign done      = in_flight && memReqFinish;

    // Instruction port only reads, so its data is zero and direction is read.
    mem_arb_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_latch_i (
        .clk       (clk),
        .rstn      (rstn),
        .start_req (startReqI),
        .in_addr   (inAddrI),
        .in_data   ('0),
        .in_rd     (1'b1),
        .owned     (owned_i),
        .take      (take_i),
        .pend      (pend_i),
        .addr      (lat_addr_i),
        .data      (lat_data_i),
        .rd        (lat_rd_i)
    );

    mem_arb_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_latch_d (
        .clk       (clk),
        .rstn      (rstn),
        .start_req (startReqD),
        .in_addr   (inAddrD),
        .in_data   (inDataD),
        .in_rd     (isRdD),
        .owned     (owned_d),
        .take      (take_d),
        .pend      (pend_d),
        .addr      (lat_addr_d),
        .data      (lat_data_d),
        .rd        (lat_rd_d)
    );

    // Arbitration FSM with registered memory-side and port-side outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            owner       <= PORT_I;
            memStartReq <= 1'b0;
            memAddr     <= '0;
            memData     <= '0;
            memIsRd     <= 1'b0;
            outDataI    <= '0;
            outDataD    <= '0;
            reqFinishI  <= 1'b0;
            reqFinishD  <= 1'b0;
            busy        <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant  <= PORT_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pend_i || pend_d) begin
                        owner       <= winner;
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        memStartReq <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_grant  <= winner;
`endif
                        if (winner == PORT_D) begin
                            memAddr <= lat_addr_d;
                            memData <= lat_data_d;
                            memIsRd <= lat_rd_d;
                        end else begin
                            memAddr <= lat_addr_i;
                            memData <= lat_data_i;
                            memIsRd <= lat_rd_i;
                        end
                    end
                end
                ISSUE: begin
                    memStartReq <= 1'b0;
                    state       <= memReqFinish ? RESP : WAIT;
                end
                WAIT: begin
                    if (memReqFinish) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    reqFinishI <= 1'b0;
                    reqFinishD <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Completion: return read data (writes keep old data) and raise the owner's pulse.
            if (done) begin
                if (owner == PORT_D) begin
                    reqFinishD <= 1'b1;
                    if (memIsRd) begin
                        outDataD <= memOutData;
                    end
                end else begin
                    reqFinishI <= 1'b1;
                    outDataI   <= memOutData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: a behavioural mem_64k responder with
// programmable latency, plus a transaction-level reference model that derives
// service order, timing and returned data from the arbitration rules.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 64;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          startReqI, startReqD, isRdD;
    logic [AW-1:0] inAddrI, inAddrD;
    logic [DW-1:0] inDataD;
    logic [DW-1:0] outDataI, outDataD;
    logic          reqFinishI, reqFinishD;
    logic          memStartReq, memIsRd, busy;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memData;
    logic [DW-1:0] memOutData = '0;
    logic          memReqFinish = 1'b0;

    mem_arb dut (
        .clk          (clk),
        .rstn         (rstn),
        .startReqI    (startReqI),
        .inAddrI      (inAddrI),
        .outDataI     (outDataI),
        .reqFinishI   (reqFinishI),
        .startReqD    (startReqD),
        .inAddrD      (inAddrD),
        .inDataD      (inDataD),
        .isRdD        (isRdD),
        .outDataD     (outDataD),
        .reqFinishD   (reqFinishD),
        .memStartReq  (memStartReq),
        .memAddr      (memAddr),
        .memData      (memData),
        .memIsRd      (memIsRd),
        .memOutData   (memOutData),
        .memReqFinish (memReqFinish),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rd;
    } bus_ev_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } fin_ev_t;

    bus_ev_t       bus_log[$];
    fin_ev_t       fin_i[$];
    fin_ev_t       fin_d[$];
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    int            mem_lat = 1;
    int            mem_cnt = 0;
    logic          mem_busy = 1'b0;
    bus_ev_t       mem_cur;

    int            n_check = 0;
    int            n_pass = 0;
    arb_port_t     model_last = PORT_I;
    logic [DW-1:0] exp_out_i = '0;
    logic [DW-1:0] exp_out_d = '0;

    // mem_64k stand-in plus output monitor, evaluated mid-cycle away from the DUT edge.
    always @(negedge clk) begin
        bus_ev_t ev;
        fin_ev_t fe;
        if (!rstn) begin
            memReqFinish = 1'b0;
            mem_busy     = 1'b0;
        end else begin
            memReqFinish = 1'b0;
            if (memStartReq) begin
                ev.cyc  = cyc;
                ev.addr = memAddr;
                ev.data = memData;
                ev.rd   = memIsRd;
                bus_log.push_back(ev);
                mem_cur  = ev;
                mem_cnt  = mem_lat;
                mem_busy = 1'b1;
            end else if (mem_busy) begin
                mem_cnt = mem_cnt - 1;
            end
            if (mem_busy && mem_cnt == 0) begin
                if (mem_cur.rd) begin
                    memOutData = bus_mem.exists(mem_cur.addr) ? bus_mem[mem_cur.addr] : '0;
                end else begin
                    bus_mem[mem_cur.addr] = mem_cur.data;
                end
                memReqFinish = 1'b1;
                mem_busy     = 1'b0;
            end
            if (reqFinishI) begin
                fe.cyc  = cyc;
                fe.data = outDataI;
                fin_i.push_back(fe);
            end
            if (reqFinishD) begin
                fe.cyc  = cyc;
                fe.data = outDataD;
                fin_d.push_back(fe);
            end
        end
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_check = n_check + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        bus_log.delete();
        fin_i.delete();
        fin_d.delete();
    endtask

    task automatic pulse(input logic do_i, input logic do_d, input logic [AW-1:0] ai,
                         input logic [AW-1:0] ad, input logic [DW-1:0] dd, input logic rd,
                         output int n);
        startReqI = do_i;
        inAddrI   = ai;
        startReqD = do_d;
        inAddrD   = ad;
        inDataD   = dd;
        isRdD     = rd;
        n = cyc;
        tick(1);
        startReqI = 1'b0;
        startReqD = 1'b0;
        inAddrI   = '0;
        inAddrD   = '0;
        inDataD   = '0;
        isRdD     = 1'b0;
    endtask

    task automatic wait_done(input int want_i, input int want_d, input int budget);
        int k = 0;
        while ((fin_i.size() < want_i || fin_d.size() < want_d) && k < budget) begin
            tick(1);
            k++;
        end
        tick(3);
    endtask

    // One request set: the model derives service order, bus timing and returned data.
    task automatic run_case(input string tag, input logic do_i, input logic do_d,
                            input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                            input logic [DW-1:0] dd, input logic rd_d, input int lat);
        arb_port_t     order[$];
        arb_port_t     p;
        int            n, s, m;
        logic [AW-1:0] ea;
        logic          er;
        mem_lat = lat;
        clear_logs();
        if (do_i && do_d) begin
            if (RR_EN && model_last == PORT_D) order = '{PORT_I, PORT_D};
            else order = '{PORT_D, PORT_I};
        end else if (do_d) begin
            order.push_back(PORT_D);
        end else begin
            order.push_back(PORT_I);
        end
        model_last = order[order.size()-1];
        pulse(do_i, do_d, ai, ad, dd, rd_d, n);
        wait_done(do_i ? 1 : 0, do_d ? 1 : 0, 150);
        check({tag, " bus accesses"}, bus_log.size(), order.size());
        check({tag, " I completions"}, fin_i.size(), do_i ? 1 : 0);
        check({tag, " D completions"}, fin_d.size(), do_d ? 1 : 0);
        m = 0;
        for (int k = 0; k < order.size(); k++) begin
            p  = order[k];
            s  = (k == 0) ? n + 2 : m + 3;
            m  = s + lat;
            ea = (p == PORT_I) ? ai : ad;
            er = (p == PORT_I) ? 1'b1 : rd_d;
            if (k < bus_log.size()) begin
                check($sformatf("%s[%0d] start cycle", tag, k), bus_log[k].cyc, s);
                check($sformatf("%s[%0d] memAddr", tag, k), bus_log[k].addr, ea);
                check($sformatf("%s[%0d] memIsRd", tag, k), bus_log[k].rd, er);
                if (!er) check($sformatf("%s[%0d] memData", tag, k), bus_log[k].data, dd);
            end
            if (er) begin
                if (p == PORT_I) exp_out_i = ref_rd(ea);
                else exp_out_d = ref_rd(ea);
            end else begin
                ref_mem[ea] = dd;
            end
            if (p == PORT_I && fin_i.size() > 0) begin
                check({tag, " reqFinishI cycle"}, fin_i[0].cyc, m + 1);
                check({tag, " outDataI"}, fin_i[0].data, exp_out_i);
            end
            if (p == PORT_D && fin_d.size() > 0) begin
                check({tag, " reqFinishD cycle"}, fin_d[0].cyc, m + 1);
                check({tag, " outDataD"}, fin_d[0].data, exp_out_d);
            end
        end
        check({tag, " busy after"}, busy, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] aset[4];
        int            n;
        int            mode;
        logic [AW-1:0] ai, ad;
        logic [DW-1:0] dd;

        aset = '{16'h0010, 16'h0100, 16'h0200, 16'h0F00};
        bus_mem[16'h0010] = 64'h1111_2222_3333_4444;
        ref_mem[16'h0010] = 64'h1111_2222_3333_4444;

        rstn      = 1'b0;
        startReqI = 1'b0;
        startReqD = 1'b0;
        inAddrI   = '0;
        inAddrD   = '0;
        inDataD   = '0;
        isRdD     = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(2);

        check("reset memStartReq", memStartReq, 1'b0);
        check("reset memAddr", memAddr, '0);
        check("reset memData", memData, '0);
        check("reset memIsRd", memIsRd, 1'b0);
        check("reset reqFinishI", reqFinishI, 1'b0);
        check("reset reqFinishD", reqFinishD, 1'b0);
        check("reset outDataI", outDataI, '0);
        check("reset outDataD", outDataD, '0);
        check("reset busy", busy, 1'b0);

        run_case("i_read", 1'b1, 1'b0, 16'h0010, '0, '0, 1'b0, 4);
        run_case("d_write", 1'b0, 1'b1, '0, 16'h0100, 64'hDEAD_BEEF_0000_0001, 1'b0, 2);
        run_case("d_read", 1'b0, 1'b1, '0, 16'h0100, '0, 1'b1, 2);

        // A second D request while one is pending, and a third while it is in flight.
        mem_lat = 4;
        clear_logs();
        pulse(1'b0, 1'b1, '0, 16'h0100, '0, 1'b1, n);
        pulse(1'b0, 1'b1, '0, 16'h0200, '0, 1'b1, n);
        tick(1);
        pulse(1'b0, 1'b1, '0, 16'h0F00, '0, 1'b1, n);
        wait_done(0, 1, 60);
        tick(6);
        model_last = PORT_D;
        exp_out_d  = ref_rd(16'h0100);
        check("dup bus accesses", bus_log.size(), 1);
        check("dup D completions", fin_d.size(), 1);
        if (bus_log.size() > 0) check("dup memAddr", bus_log[0].addr, 16'h0100);
        if (fin_d.size() > 0) check("dup outDataD", fin_d[0].data, exp_out_d);

        run_case("zero_lat", 1'b1, 1'b0, 16'h0010, '0, '0, 1'b0, 0);

        // Reset while the memory is still working on a D read.
        mem_lat = 10;
        clear_logs();
        pulse(1'b0, 1'b1, '0, 16'h0100, '0, 1'b1, n);
        tick(3);
        check("wait busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        check("abort memStartReq", memStartReq, 1'b0);
        check("abort memAddr", memAddr, '0);
        check("abort memIsRd", memIsRd, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort outDataI", outDataI, '0);
        check("abort outDataD", outDataD, '0);
        check("abort reqFinishD", reqFinishD, 1'b0);
        exp_out_i  = '0;
        exp_out_d  = '0;
        model_last = PORT_I;
        tick(2);
        rstn = 1'b1;
        tick(15);
        check("abort no D completion", fin_d.size(), 0);
        check("abort no new access", bus_log.size(), 1);
        run_case("post_reset", 1'b1, 1'b0, 16'h0010, '0, '0, 1'b0, 1);

        run_case("tie1", 1'b1, 1'b1, 16'h0010, 16'h0100, '0, 1'b1, 3);
        run_case("d_only", 1'b0, 1'b1, '0, 16'h0200, 64'h0123_4567_89AB_CDEF, 1'b0, 1);
        run_case("tie2", 1'b1, 1'b1, 16'h0200, 16'h0010, 64'h5555_AAAA_5555_AAAA, 1'b0, 2);

        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(1, 3);
            ai   = aset[$urandom_range(0, 3)];
            ad   = aset[$urandom_range(0, 3)];
            dd   = {$urandom, $urandom};
            run_case($sformatf("rnd%0d", it), (mode != 2), (mode != 1), ai, ad, dd,
                     1'($urandom_range(0, 1)), $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
